// File: rtl/multdiv_ctrl_pkg.sv
// rtl/multdiv_ctrl_pkg.sv - shared types and parameter helpers for the multdiv sequencer
// Contents: state encoding enum, default step-count and counter-width derivation.
package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Radix-4 Booth retires two multiplier bits per iteration.
  function automatic int default_mult_steps(input int width);
    return width / 2;
  endfunction

  // Restoring division retires one quotient bit per iteration.
  function automatic int default_div_steps(input int width);
    return width;
  endfunction

  // One spare bit over the largest index keeps N-1 comparisons unsigned-safe.
  function automatic int default_cnt_w(input int mult_steps, input int div_steps);
    return $clog2((mult_steps > div_steps) ? mult_steps : div_steps) + 1;
  endfunction

endpackage

// File: rtl/multdiv_ctrl_seq_if.sv
// rtl/multdiv_ctrl_seq_if.sv - request/strobe bundle between execute stage and multdiv sequencer
// master: execute side, drives ctrl_MULT/ctrl_DIV, observes status and strobes.
// slave:  sequencer side, samples requests, drives busy/is_div/load/step_en/step/last_step/result_rdy.
interface multdiv_ctrl_seq_if #(
  parameter int CNT_W = 6
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             busy;
  logic             is_div;
  logic             load;
  logic             step_en;
  logic [CNT_W-1:0] step;
  logic             last_step;
  logic             result_rdy;

  modport master (
    output ctrl_MULT, ctrl_DIV,
    input  busy, is_div, load, step_en, step, last_step, result_rdy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV,
    output busy, is_div, load, step_en, step, last_step, result_rdy
  );
endinterface

// File: rtl/multdiv_ctrl_reg.sv
// rtl/multdiv_ctrl_reg.sv - enabled register with synchronous clear to a parameter value
// Ports: clk, clr (sync, active-high), en (load enable), d (next value), q (stored value).
module multdiv_ctrl_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/multdiv_ctrl_seq.sv
// rtl/multdiv_ctrl_seq.sv - counted IDLE/LOAD/RUN/DONE sequencer for the iterative multiplier/divider
// Ports: clk, clr (sync, active-high), bus (slave modport: requests in, Moore strobes out).
module multdiv_ctrl_seq
  import multdiv_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MULT_STEPS = default_mult_steps(WIDTH),
  parameter int DIV_STEPS  = default_div_steps(WIDTH),
  parameter int CNT_W      = default_cnt_w(MULT_STEPS, DIV_STEPS)
) (
  input  logic                clk,
  input  logic                clr,
  multdiv_ctrl_seq_if.slave   bus
);

  logic [1:0]       state_q;
  state_e           state;
  state_e           state_d;
  logic [CNT_W-1:0] step_q;
  logic [CNT_W-1:0] step_d;
  logic [CNT_W-1:0] n_last;
  logic             is_div_q;
  logic             is_div_d;
  logic             start;
  logic             start_div;

  assign state     = state_e'(state_q);
  assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
  // Multiply wins when both requests arrive together.
  assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
  assign n_last    = is_div_q ? CNT_W'(DIV_STEPS - 1) : CNT_W'(MULT_STEPS - 1);

  always_comb begin
    state_d  = state;
    step_d   = step_q;
    is_div_d = is_div_q;
    // A start in any state (re)launches: from IDLE/DONE it issues, from LOAD/RUN it aborts.
    if (start) begin
      state_d  = LOAD;
      step_d   = '0;
      is_div_d = start_div;
    end else begin
      case (state)
        IDLE: state_d = IDLE;
        LOAD: begin
          state_d = RUN;
          step_d  = '0;
        end
        RUN: begin
          if (step_q == n_last) begin
            state_d = DONE;
          end else begin
            step_d = step_q + CNT_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  multdiv_ctrl_reg #(.W(2), .RST_VAL(2'b00)) u_state_reg (
    .clk (clk),
    .clr (clr),
    .en  (1'b1),
    .d   (state_d),
    .q   (state_q)
  );

  multdiv_ctrl_reg #(.W(CNT_W), .RST_VAL('0)) u_step_reg (
    .clk (clk),
    .clr (clr),
    .en  (1'b1),
    .d   (step_d),
    .q   (step_q)
  );

  multdiv_ctrl_reg #(.W(1), .RST_VAL(1'b0)) u_is_div_reg (
    .clk (clk),
    .clr (clr),
    .en  (1'b1),
    .d   (is_div_d),
    .q   (is_div_q)
  );

  assign bus.busy       = (state == LOAD) || (state == RUN);
  assign bus.is_div     = is_div_q;
  assign bus.load       = (state == LOAD);
  assign bus.step_en    = (state == RUN);
  assign bus.step       = step_q;
  assign bus.last_step  = (state == RUN) && (step_q == n_last);
  assign bus.result_rdy = (state == DONE);

endmodule

// File: tb/tb_multdiv_ctrl_seq.sv
// tb/tb_multdiv_ctrl_seq.sv - self-checking bench for multdiv_ctrl_seq with result scoreboard
module tb_multdiv_ctrl_seq;

  localparam int MN  = 16;
  localparam int DN  = 32;
  localparam int CW  = 6;
  localparam int CW2 = 3;

  typedef struct {
    int   cyc;
    logic is_div;
  } exp_t;

  logic clk;
  logic clr;
  logic clr2;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  multdiv_ctrl_seq_if #(.CNT_W(CW))  bus ();
  multdiv_ctrl_seq_if #(.CNT_W(CW2)) bus2 ();

  multdiv_ctrl_seq dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  multdiv_ctrl_seq #(.WIDTH(32), .MULT_STEPS(1), .DIV_STEPS(3), .CNT_W(CW2)) dut2 (
    .clk (clk),
    .clr (clr2),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for the default-parameter DUT.
  always @(negedge clk) begin
    exp_t e;
    if (bus.result_rdy === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL result_rdy_unexpected cycle=%0d got=1 expected=0", cyc);
      end else begin
        e = sb.pop_front();
        if (e.cyc !== cyc || e.is_div !== bus.is_div) begin
          n_fail++;
          $display("FAIL result_rdy_match got cycle=%0d is_div=%b expected cycle=%0d is_div=%b",
                   cyc, bus.is_div, e.cyc, e.is_div);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      n_checks++;
      n_fail++;
      e = sb.pop_front();
      $display("FAIL result_rdy_missing cycle=%0d got=0 expected=1", e.cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    clr2 = 1'b1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus2.ctrl_MULT = 1'b0;
    bus2.ctrl_DIV = 1'b0;
    tick();
    clr = 1'b0;
    clr2 = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.ctrl_MULT = 1'b1;
    bus.ctrl_DIV = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus.busy, bus.is_div, bus.load, bus.step_en, bus.last_step, bus.result_rdy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes got=%b expected=000000",
               {bus.busy, bus.is_div, bus.load, bus.step_en, bus.last_step, bus.result_rdy});
    end
    n_checks++;
    if (bus.step !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_step got=%0d expected=0", bus.step);
    end
    n_checks++;
    if (dut.state_q !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state got=%b expected=00", dut.state_q);
    end
    clr = 1'b0;
    bus.ctrl_MULT = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.load !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_hold got busy=%b load=%b expected 0 0", bus.busy, bus.load);
    end
  endtask

  task automatic test_mult();
    int t0;
    t0 = cyc;
    sb.push_back('{cyc: t0 + MN + 2, is_div: 1'b0});
    for (int k = 0; k <= MN + 4; k++) begin
      bus.ctrl_MULT = (k == 0);
      n_checks++;
      if ({bus.load, bus.step_en, bus.last_step, bus.busy} !==
          {k == 1, k >= 2 && k <= MN + 1, k == MN + 1, k >= 1 && k <= MN + 1}) begin
        n_fail++;
        $display("FAIL mult_strobes k=%0d got load/step_en/last/busy=%b%b%b%b", k,
                 bus.load, bus.step_en, bus.last_step, bus.busy);
      end
      if (k >= 2 && k <= MN + 1) begin
        n_checks++;
        if (bus.step !== 6'(k - 2)) begin
          n_fail++;
          $display("FAIL mult_step k=%0d got=%0d expected=%0d", k, bus.step, k - 2);
        end
      end
      if (k == MN + 2) begin
        n_checks++;
        if (bus.step !== 6'(MN - 1)) begin
          n_fail++;
          $display("FAIL mult_step_hold got=%0d expected=%0d", bus.step, MN - 1);
        end
      end
      tick();
    end
  endtask

  task automatic test_div();
    int t0;
    int max_step;
    t0 = cyc;
    max_step = 0;
    sb.push_back('{cyc: t0 + DN + 2, is_div: 1'b1});
    for (int k = 0; k <= DN + 4; k++) begin
      bus.ctrl_DIV = (k == 0);
      if (k >= 1 && k <= DN + 2) begin
        n_checks++;
        if (bus.is_div !== 1'b1) begin
          n_fail++;
          $display("FAIL div_is_div k=%0d got=%b expected=1", k, bus.is_div);
        end
      end
      n_checks++;
      if ({bus.step_en, bus.last_step} !== {k >= 2 && k <= DN + 1, k == DN + 1}) begin
        n_fail++;
        $display("FAIL div_strobes k=%0d got step_en/last=%b%b", k, bus.step_en, bus.last_step);
      end
      if (bus.step_en === 1'b1 && int'(bus.step) > max_step) max_step = int'(bus.step);
      tick();
    end
    n_checks++;
    if (max_step !== DN - 1) begin
      n_fail++;
      $display("FAIL div_max_step got=%0d expected=%0d", max_step, DN - 1);
    end
  endtask

  task automatic test_restart();
    int t0;
    t0 = cyc;
    sb.push_back('{cyc: t0 + 10 + DN + 2, is_div: 1'b1});
    for (int k = 0; k <= 10 + DN + 4; k++) begin
      bus.ctrl_MULT = (k == 0);
      bus.ctrl_DIV = (k == 10);
      n_checks++;
      if (bus.load !== (k == 1 || k == 11)) begin
        n_fail++;
        $display("FAIL restart_load k=%0d got=%b expected=%b", k, bus.load, (k == 1 || k == 11));
      end
      if (k == 11) begin
        n_checks++;
        if (bus.is_div !== 1'b1 || bus.step !== 6'd0) begin
          n_fail++;
          $display("FAIL restart_relatch got is_div=%b step=%0d expected 1 0", bus.is_div, bus.step);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = cyc;
    sb.push_back('{cyc: t0 + MN + 2, is_div: 1'b0});
    sb.push_back('{cyc: t0 + 2 * (MN + 2), is_div: 1'b0});
    for (int k = 0; k <= 2 * (MN + 2) + 2; k++) begin
      bus.ctrl_MULT = (k == 0 || k == MN + 2);
      bus.ctrl_DIV = (k == 0);
      if (k == 1) begin
        n_checks++;
        if (bus.is_div !== 1'b0) begin
          n_fail++;
          $display("FAIL both_start_is_div got=%b expected=0", bus.is_div);
        end
      end
      n_checks++;
      if (bus.load !== (k == 1 || k == MN + 3)) begin
        n_fail++;
        $display("FAIL b2b_load k=%0d got=%b expected=%b", k, bus.load, (k == 1 || k == MN + 3));
      end
      tick();
    end
  endtask

  task automatic test_clear_mid();
    int pulses;
    pulses = 0;
    for (int k = 0; k <= DN + 6; k++) begin
      bus.ctrl_DIV = (k == 0);
      clr = (k == 7);
      if (k == 8) begin
        n_checks++;
        if ({bus.busy, bus.is_div, bus.step_en, bus.load} !== 4'b0 || bus.step !== 6'd0) begin
          n_fail++;
          $display("FAIL clear_mid got busy/is_div/step_en/load=%b%b%b%b step=%0d expected 0000 0",
                   bus.busy, bus.is_div, bus.step_en, bus.load, bus.step);
        end
      end
      if (bus.result_rdy === 1'b1) pulses++;
      tick();
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL clear_no_result got=%0d pulses expected=0", pulses);
    end
  endtask

  task automatic test_small_params();
    for (int k = 0; k <= 16; k++) begin
      bus2.ctrl_MULT = (k == 0);
      bus2.ctrl_DIV = (k == 10);
      n_checks++;
      if ({bus2.load, bus2.step_en, bus2.last_step, bus2.result_rdy} !==
          {k == 1 || k == 11, k == 2 || (k >= 12 && k <= 14), k == 2 || k == 14, k == 3 || k == 15}) begin
        n_fail++;
        $display("FAIL small_strobes k=%0d got load/step_en/last/rdy=%b%b%b%b", k,
                 bus2.load, bus2.step_en, bus2.last_step, bus2.result_rdy);
      end
      if (k >= 12 && k <= 14) begin
        n_checks++;
        if (bus2.step !== 3'(k - 12)) begin
          n_fail++;
          $display("FAIL small_div_step k=%0d got=%0d expected=%0d", k, bus2.step, k - 12);
        end
      end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    clr = 1'b1;
    clr2 = 1'b1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus2.ctrl_MULT = 1'b0;
    bus2.ctrl_DIV = 1'b0;
    tick();
    test_reset();
    do_reset();
    test_mult();
    do_reset();
    test_div();
    do_reset();
    test_restart();
    do_reset();
    test_back_to_back();
    do_reset();
    test_clear_mid();
    do_reset();
    test_small_params();
    tick();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl_seq.md
# multdiv_ctrl_seq

Parametrised sequencer for the iterative multiplier/divider. It replaces the ad-hoc single-bit control flops with a counted state machine. It accepts one-cycle `ctrl_MULT`/`ctrl_DIV` requests and drives the datapath's operand-load and step-enable strobes. It raises `result_rdy` after a configurable number of iterations and sits between the processor's execute stage and the multdiv datapath.

## Interface
Parameters:
- `WIDTH`, 32: operand width; informational, used only for the default step counts.
- `MULT_STEPS`, `WIDTH/2` (16): iterations per multiply (radix-4 Booth). Must be ≥1.
- `DIV_STEPS`, `WIDTH` (32): iterations per divide (restoring). Must be ≥1.
- `CNT_W`, `$clog2(max(MULT_STEPS,DIV_STEPS))+1` (6): step counter width.

Ports:
- `clk` in 1: the single clock. All state updates on the rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `ctrl_MULT` in 1: start-multiply request, sampled each edge.
- `ctrl_DIV` in 1: start-divide request, sampled each edge.
- `busy` out 1: high in LOAD and RUN.
- `is_div` out 1: operation type latched at start (1 = divide).
- `load` out 1: high for exactly the LOAD cycle; datapath captures operands.
- `step_en` out 1: high in every RUN cycle; datapath advances one iteration.
- `step` out CNT_W: current iteration index, 0-based.
- `last_step` out 1: high in the final RUN cycle (`step == N-1`).
- `result_rdy` out 1: one-cycle pulse in DONE.

## Operation
- States: IDLE, LOAD, RUN, DONE. All outputs are Moore, decoded from the state, `step` and `is_div` registers.
- N = `DIV_STEPS` if `is_div`, else `MULT_STEPS`.
- A start is `ctrl_MULT | ctrl_DIV`.
  - Both asserted in the same cycle: multiply wins, `is_div`←0.
- IDLE: on start → LOAD; latch `is_div`; `step`←0. Otherwise hold.
- LOAD: unconditionally → RUN with `step`=0, unless a start arrives (see restart).
- RUN: `step`←`step`+1 each cycle. When `step==N-1` → DONE; `step` holds at N-1.
- DONE: → IDLE, or → LOAD if a start is present (back-to-back issue, no idle bubble).
- Restart: a start in LOAD or RUN aborts the current operation.
  - Next state is LOAD with the new `is_div`; `step`←0.
  - No `result_rdy` is emitted for the aborted operation.
- `clr` in any state, including mid-RUN: next cycle state=IDLE, `step`=0, `is_div`=0, all strobes 0. `clr` overrides a simultaneous start.
- Reset values: `busy`=0, `is_div`=0, `load`=0, `step_en`=0, `step`=0, `last_step`=0, `result_rdy`=0.
- Counter arithmetic is unsigned. `step` never exceeds N-1, so there is no wrap-around.

## Timing
- Start sampled at edge E0 (request high in cycle 0) → LOAD in cycle 1 → RUN in cycles 2..N+1 → DONE in cycle N+2.
- Latency from start to `result_rdy`: N+2 cycles.
  - Multiply: 18 at defaults.
  - Divide: 34 at defaults.
- Throughput with back-to-back requests (start held in the DONE cycle): one result per N+2 cycles.
- A start held high for several cycles is treated as repeated restarts. The requester must pulse for one cycle.

## Structure
- Package `multdiv_ctrl_pkg` holds:
  - state encoding localparams: IDLE=2'b00, LOAD=2'b01, RUN=2'b10, DONE=2'b11;
  - default `MULT_STEPS`/`DIV_STEPS` derivation from `WIDTH`.
- Sub-module `multdiv_ctrl_reg`: parametrised register with parameters `W` and `RST_VAL`, ports `clk`, `clr` (synchronous), `en`, `d`, `q`. Instantiated three times:
  - 2-bit state register;
  - `CNT_W` step counter;
  - 1-bit `is_div`.
- Top level holds only next-state/next-count logic and output decode.

## Test plan
- Reset: hold `clr` 2 cycles with `ctrl_MULT`=1 → all outputs 0, state IDLE.
- Multiply at defaults: pulse `ctrl_MULT` in cycle 0 → `load` in cycle 1; `step_en` in cycles 2–17 with `step` 0..15; `last_step` only in cycle 17; `result_rdy` only in cycle 18; `busy` high in cycles 1–17.
- Divide at defaults: pulse `ctrl_DIV` → `is_div`=1, `result_rdy` in cycle 34, `step` reaches 31.
- Restart: `ctrl_MULT` in cycle 0, `ctrl_DIV` in cycle 10 → `load` in cycle 11, no `result_rdy` in cycle 18, `result_rdy` in cycle 44.
- Simultaneous start and back-to-back:
  - both requests in cycle 0 → `is_div`=0;
  - a second `ctrl_MULT` in cycle 18 (DONE) → `load` in cycle 19, `result_rdy` in cycle 36.
- Mid-operation clear, plus non-default parameters:
  - `clr` in cycle 7 of a divide → IDLE in cycle 8, no `result_rdy` thereafter;
  - repeat with `MULT_STEPS`=1 → `result_rdy` in cycle 3.
